// File: rtl/sha256d_nonce_scheduler_pkg.sv
// Shared types and address map for the sha256d nonce scheduler.
package sha256d_nonce_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_START,
    ST_RUN,
    ST_CHECK
  } state_e;

  localparam logic [4:0] HDR_LAST   = 5'd18;
  localparam logic [4:0] A_NSTART   = 5'd19;
  localparam logic [4:0] A_NEND     = 5'd20;
  localparam logic [4:0] A_DIFF     = 5'd21;
  localparam logic [4:0] NONCE_WORD = 5'd19;

endpackage

// File: rtl/sha256d_nonce_scheduler_if.sv
// Word-request / control bus between the scheduler (master) and the sha256d core (slave).
interface sha256d_nonce_scheduler_if;
  logic         core_rst_n;
  logic         core_start;
  logic [4:0]   core_addr;
  logic         core_rq;
  logic [31:0]  core_data;
  logic         core_rdy;
  logic [255:0] core_hash;
  logic         core_done;

  modport master (
    output core_rst_n, core_start, core_data, core_rdy,
    input  core_addr, core_rq, core_hash, core_done
  );

  modport slave (
    input  core_rst_n, core_start, core_data, core_rdy,
    output core_addr, core_rq, core_hash, core_done
  );
endinterface

// File: rtl/sha256d_diff_check.sv
// Difficulty test: byte-reverse the core hash, then require the top diff_bits bits to be zero.
module sha256d_diff_check #(
  parameter int DIFF_W = 8
) (
  input  logic [255:0]      hash,
  input  logic [DIFF_W-1:0] diff_bits,
  output logic              pass
);

  logic [255:0] rev;

  always_comb begin
    rev = '0;
    for (int i = 0; i < 32; i++) begin
      rev[8*i +: 8] = hash[8*(31-i) +: 8];
    end
  end

  always_comb begin
    pass = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if ((i < int'(diff_bits)) && rev[255-i]) pass = 1'b0;
    end
  end

endmodule

// File: rtl/sha256d_nonce_scheduler.sv
// Nonce-range job controller: serves header words to the sha256d core, restarts it
// once per nonce and records the first (or last) nonce whose hash meets the difficulty.
module sha256d_nonce_scheduler
  import sha256d_nonce_scheduler_pkg::*;
#(
  parameter int RST_CYCLES    = 2,
  parameter bit STOP_ON_FOUND = 1'b1,
  parameter int DIFF_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_we,
  input  logic [4:0]                  cfg_addr,
  input  logic [31:0]                 cfg_wdata,
  input  logic                        go,
  input  logic                        abort,
  output logic                        busy,
  output logic                        found,
  output logic                        exhausted,
  output logic [31:0]                 found_nonce,
  output logic [255:0]                found_hash,
  sha256d_nonce_scheduler_if.master   core
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hdr_q [0:18];
  logic [31:0]        hdr_d [0:18];
  logic [31:0]        nstart_q, nstart_d, nend_q, nend_d, nonce_q, nonce_d;
  logic [DIFF_W-1:0]  diff_q, diff_d;
  logic [255:0]       hash_q, hash_d, fhash_q, fhash_d;
  logic [31:0]        fnonce_q, fnonce_d;
  logic               found_q, found_d, exh_q, exh_d;
  logic               core_rst_n_q, core_rst_n_d, core_start_q, core_start_d;
  logic               rel_q, rel_d;
  logic               pass, abort_now;

  sha256d_diff_check #(.DIFF_W(DIFF_W)) u_diff (
    .hash      (hash_q),
    .diff_bits (diff_q),
    .pass      (pass)
  );

  assign abort_now = abort && (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    nstart_d = nstart_q;
    nend_d   = nend_q;
    diff_d   = diff_q;
    nonce_d  = nonce_q;
    hash_d   = hash_q;
    found_d  = found_q;
    exh_d    = exh_q;
    fnonce_d = fnonce_q;
    fhash_d  = fhash_q;

    if (cfg_we && (state_q == ST_IDLE)) begin
      if (cfg_addr <= HDR_LAST)      hdr_d[cfg_addr] = cfg_wdata;
      else if (cfg_addr == A_NSTART) nstart_d = cfg_wdata;
      else if (cfg_addr == A_NEND)   nend_d   = cfg_wdata;
      else if (cfg_addr == A_DIFF)   diff_d   = cfg_wdata[DIFF_W-1:0];
    end

    // abort overrides every other transition, leaving the result flags untouched
    if (abort_now) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go && !abort) begin
            state_d = ST_RESET;
            cnt_d   = '0;
            found_d = 1'b0;
            exh_d   = 1'b0;
            nonce_d = nstart_q;
          end
        end
        ST_RESET: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_START;
          else                                 cnt_d   = cnt_q + 1'b1;
        end
        ST_START: state_d = ST_RUN;
        ST_RUN: begin
          if (core.core_done) begin
            state_d = ST_CHECK;
            hash_d  = core.core_hash;
          end
        end
        ST_CHECK: begin
          if (pass) begin
            found_d  = 1'b1;
            fnonce_d = nonce_q;
            fhash_d  = hash_q;
          end
          if (pass && STOP_ON_FOUND) begin
            state_d = ST_IDLE;
          end else if (nonce_q == nend_q) begin
            state_d = ST_IDLE;
            exh_d   = !(found_q || pass);
          end else begin
            nonce_d = nonce_q + 32'd1;
            cnt_d   = '0;
            state_d = ST_RESET;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Core controls are registered from the next state so they line up with state_q;
    // the core stays in reset after power-up until the first RESET pass completes.
    rel_d        = rel_q || ((state_q == ST_RESET) && (state_d == ST_START));
    core_start_d = (state_d == ST_START);
    core_rst_n_d = !abort_now && (state_d != ST_RESET) && ((state_d != ST_IDLE) || rel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hdr_q        <= '{default: '0};
      nstart_q     <= '0;
      nend_q       <= '0;
      diff_q       <= '0;
      nonce_q      <= '0;
      hash_q       <= '0;
      found_q      <= 1'b0;
      exh_q        <= 1'b0;
      fnonce_q     <= '0;
      fhash_q      <= '0;
      core_rst_n_q <= 1'b0;
      core_start_q <= 1'b0;
      rel_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hdr_q        <= hdr_d;
      nstart_q     <= nstart_d;
      nend_q       <= nend_d;
      diff_q       <= diff_d;
      nonce_q      <= nonce_d;
      hash_q       <= hash_d;
      found_q      <= found_d;
      exh_q        <= exh_d;
      fnonce_q     <= fnonce_d;
      fhash_q      <= fhash_d;
      core_rst_n_q <= core_rst_n_d;
      core_start_q <= core_start_d;
      rel_q        <= rel_d;
    end
  end

  // Zero-latency word serving, only while the core is running
  always_comb begin
    core.core_rdy  = 1'b0;
    core.core_data = '0;
    if (state_q == ST_RUN) begin
      core.core_rdy = core.core_rq && (core.core_addr <= NONCE_WORD);
      if (core.core_addr <= HDR_LAST)        core.core_data = hdr_q[core.core_addr];
      else if (core.core_addr == NONCE_WORD) core.core_data = nonce_q;
    end
  end

  assign core.core_rst_n = core_rst_n_q & rst_n;
  assign core.core_start = core_start_q;
  assign busy            = (state_q != ST_IDLE);
  assign found           = found_q;
  assign exhausted       = exh_q;
  assign found_nonce     = fnonce_q;
  assign found_hash      = fhash_q;

endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// Bench for sha256d_nonce_scheduler: a fake sha256d core plus a job-level model of the nonce search.
module tb_sha256d_nonce_scheduler;

  localparam int RST_CYCLES = 2;
  localparam logic [255:0] GEN_CORE    = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [255:0] GEN_DISPLAY = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_we = 1'b0;
  logic [4:0]   cfg_addr = '0;
  logic [31:0]  cfg_wdata = '0;
  logic         go = 1'b0;
  logic         abort = 1'b0;
  logic         busy, found, exhausted;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;

  sha256d_nonce_scheduler_if cif ();

  sha256d_nonce_scheduler #(
    .RST_CYCLES    (RST_CYCLES),
    .STOP_ON_FOUND (1'b1),
    .DIFF_W        (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .go          (go),
    .abort       (abort),
    .busy        (busy),
    .found       (found),
    .exhausted   (exhausted),
    .found_nonce (found_nonce),
    .found_hash  (found_hash),
    .core        (cif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stimulus definition of the fake core's hash for a given nonce word
  function automatic logic [255:0] fake_hash(input logic [31:0] n);
    return GEN_CORE ^ {n ^ 32'h1DAC2B7C, 224'b0};
  endfunction

  function automatic bit model_pass(input logic [255:0] h, input logic [7:0] d);
    logic [255:0] rev;
    rev = {<<8{h}};
    if (d == 8'd0) return 1'b1;
    return (rev >> (256 - int'(d))) == 256'b0;
  endfunction

  // ---------------- job model ----------------
  logic [31:0]  hdr_m [19];
  logic [31:0]  nstart_m = '0, nend_m = '0;
  logic [7:0]   diff_m = '0;
  logic [31:0]  exp_q[$];
  bit           m_found, m_exh;
  logic [31:0]  m_fnonce;
  logic [255:0] m_fhash;

  task automatic model_job();
    logic [31:0] n;
    exp_q.delete();
    m_found = 1'b0;
    m_exh = 1'b0;
    n = nstart_m;
    for (int k = 0; k < 64; k++) begin
      exp_q.push_back(n);
      if (model_pass(fake_hash(n), diff_m)) begin
        m_found = 1'b1;
        m_fnonce = n;
        m_fhash = fake_hash(n);
        break;
      end
      if (n == nend_m) begin
        m_exh = !m_found;
        break;
      end
      n = n + 32'd1;
    end
  endtask

  // ---------------- fake sha256d core ----------------
  int          fc_phase = 0;
  int          fc_wait = 0;
  logic [31:0] fc_words [20];
  logic [31:0] served19[$];

  always @(posedge clk) begin
    #1;
    if (!cif.core_rst_n) begin
      fc_phase = 0;
      cif.core_rq = 1'b0;
      cif.core_addr = '0;
      cif.core_done = 1'b0;
      cif.core_hash = '0;
    end else begin
      case (fc_phase)
        0: if (cif.core_start) begin
             fc_phase = 1;
             cif.core_addr = '0;
             cif.core_rq = 1'b1;
           end
        1: if (cif.core_rdy) begin
             fc_words[cif.core_addr] = cif.core_data;
             if (cif.core_addr == 5'd19) begin
               served19.push_back(cif.core_data);
               cif.core_rq = 1'b0;
               fc_wait = 3;
               fc_phase = 2;
             end else begin
               cif.core_addr = cif.core_addr + 5'd1;
             end
           end
        2: if (fc_wait == 0) begin
             cif.core_done = 1'b1;
             cif.core_hash = fake_hash(fc_words[19]);
             fc_phase = 3;
           end else begin
             fc_wait--;
           end
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  int          starts = 0;
  int          base = 0;
  int          low_len = 0;
  int          last_low = 0;
  bit          run_m = 1'b0;
  int          idx;
  logic        exp_rdy;
  logic [31:0] exp_data;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy) run_m = 1'b0;
      if (busy && !cif.core_rst_n) begin
        low_len++;
      end else if (cif.core_rst_n && (low_len != 0)) begin
        last_low = low_len;
        low_len = 0;
      end

      exp_rdy = run_m && cif.core_rq && (cif.core_addr <= 5'd19);
      chk("core_rdy", cif.core_rdy, exp_rdy);
      exp_data = '0;
      if (run_m) begin
        if (cif.core_addr <= 5'd18) begin
          exp_data = hdr_m[cif.core_addr];
        end else if (cif.core_addr == 5'd19) begin
          idx = starts - base - 1;
          if (idx >= 0 && idx < exp_q.size()) exp_data = exp_q[idx];
          else exp_data = 32'hxxxxxxxx;
        end
      end
      chk("core_data", cif.core_data, exp_data);

      if (cif.core_start) begin
        starts++;
        chk("start_while_busy", busy, 1'b1);
        chk("rst_window", last_low, RST_CYCLES);
        last_low = 0;
      end
      if (cif.core_done) run_m = 1'b0;
      if (cif.core_start) run_m = 1'b1;
    end
  end

  // ---------------- sequencer ----------------
  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    if (a <= 5'd18) hdr_m[a] = d;
    else if (a == 5'd19) nstart_m = d;
    else if (a == 5'd20) nend_m = d;
    else if (a == 5'd21) diff_m = d[7:0];
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic start_job();
    model_job();
    served19.delete();
    @(negedge clk);
    base = starts;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    for (t = 0; t < 3000 && busy; t++) @(negedge clk);
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, t);
    end
  endtask

  task automatic check_job(input string name);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_found"}, found, m_found);
    chk({name, "_exhausted"}, exhausted, m_exh);
    if (m_found) begin
      chk({name, "_fnonce"}, found_nonce, m_fnonce);
      chk({name, "_fhash"}, found_hash, m_fhash);
    end
    chk({name, "_hashes"}, starts - base, exp_q.size());
    chk({name, "_served19_cnt"}, served19.size(), exp_q.size());
    for (int k = 0; k < served19.size() && k < exp_q.size(); k++)
      chk({name, "_served19"}, served19[k], exp_q[k]);
  endtask

  logic [31:0] gen_hdr [19] = '{
    32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
    32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d
  };

  logic [255:0] rev_fh;
  int           t;

  initial begin
    for (int k = 0; k < 19; k++) hdr_m[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_core_rst_n_in_reset", cif.core_rst_n, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_found", found, 1'b0);
    chk("rst_exhausted", exhausted, 1'b0);
    chk("rst_found_nonce", found_nonce, 32'h0);
    chk("rst_found_hash", found_hash, 256'h0);
    chk("rst_core_start", cif.core_start, 1'b0);
    chk("rst_core_rst_n", cif.core_rst_n, 1'b0);

    // 1: genesis block, difficulty 40
    for (int k = 0; k < 19; k++) cfg_wr(k[4:0], gen_hdr[k]);
    cfg_wr(5'd19, 32'h1DAC2B7C);
    cfg_wr(5'd20, 32'h1DAC2B7C);
    cfg_wr(5'd21, 32'd40);
    cfg_wr(5'd25, 32'hFFFFFFFF);
    start_job();
    wait_done("t1");
    check_job("t1");
    chk("t1_found_lit", found, 1'b1);
    chk("t1_fnonce_lit", found_nonce, 32'h1DAC2B7C);
    rev_fh = {<<8{found_hash}};
    chk("t1_hash_rev_lit", rev_fh, GEN_DISPLAY);
    chk("t1_one_start_lit", starts - base, 1);

    // 2: same job, difficulty 44 just misses (43 leading zeros)
    cfg_wr(5'd21, 32'd44);
    start_job();
    wait_done("t2");
    check_job("t2");
    chk("t2_found_lit", found, 1'b0);
    chk("t2_exhausted_lit", exhausted, 1'b1);
    chk("t2_one_start_lit", starts - base, 1);

    // 3: difficulty 0 stops on first nonce
    cfg_wr(5'd19, 32'd5);
    cfg_wr(5'd20, 32'd7);
    cfg_wr(5'd21, 32'd0);
    start_job();
    wait_done("t3");
    check_job("t3");
    chk("t3_fnonce_lit", found_nonce, 32'd5);
    chk("t3_one_start_lit", starts - base, 1);

    // 4: range wrapping through zero, impossible difficulty
    cfg_wr(5'd19, 32'hFFFFFFFF);
    cfg_wr(5'd20, 32'h00000000);
    cfg_wr(5'd21, 32'd255);
    start_job();
    wait_done("t4");
    check_job("t4");
    chk("t4_two_starts_lit", starts - base, 2);
    chk("t4_exhausted_lit", exhausted, 1'b1);
    if (served19.size() == 2) begin
      chk("t4_word19_first_lit", served19[0], 32'hFFFFFFFF);
      chk("t4_word19_second_lit", served19[1], 32'h00000000);
    end else begin
      chk("t4_word19_count_lit", served19.size(), 2);
    end

    // 5: abort midway through word serving, then rerun
    cfg_wr(5'd19, 32'd100);
    cfg_wr(5'd20, 32'd101);
    start_job();
    for (t = 0; t < 200 && !(cif.core_rq && cif.core_addr >= 5'd10); t++) @(negedge clk);
    chk("t5_reached_mid_serving", cif.core_rq && (cif.core_addr >= 5'd10), 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_busy_after_abort", busy, 1'b0);
    chk("t5_core_rst_low", cif.core_rst_n, 1'b0);
    chk("t5_found_after_abort", found, 1'b0);
    chk("t5_exh_after_abort", exhausted, 1'b0);
    @(negedge clk);
    chk("t5_core_rst_released", cif.core_rst_n, 1'b1);
    start_job();
    wait_done("t5");
    check_job("t5");
    if (served19.size() > 0) chk("t5_restart_nonce_lit", served19[0], 32'd100);

    // 6: config write while busy is ignored; go+abort in IDLE starts nothing
    start_job();
    repeat (3) @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 5'd3; cfg_wdata = 32'hDEADBEEF;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_done("t6");
    check_job("t6");
    chk("t6_word3_unchanged_lit", fc_words[3], 32'h0);
    base = starts;
    go = 1'b1; abort = 1'b1;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_goabort_busy", busy, 1'b0);
    chk("t6_goabort_no_start", starts - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
